// File: rtl/fine_delay_interp_pkg.sv
// Shared DBF constants and helpers for the fine-delay interpolator.
package fine_delay_interp_pkg;

  localparam int INPUT_WD  = 14;
  localparam int FRAC_WD   = 4;
  localparam int FD_OUT_WD = INPUT_WD + FRAC_WD;
  localparam int ADDR_WD   = 7;
  localparam int ZONE_LEN  = 64;

  // Interpolation weights always sum to UNITY.
  localparam int UNITY     = 1 << FRAC_WD;
  localparam int CNT_WD    = (ZONE_LEN > 1) ? $clog2(ZONE_LEN) : 1;

  typedef logic signed [INPUT_WD-1:0]  sample_t;
  typedef logic        [FRAC_WD-1:0]   code_t;
  typedef logic        [FRAC_WD:0]     weight_t;
  typedef logic signed [FD_OUT_WD-1:0] fd_out_t;

  // Weight applied to the current sample: UNITY - f.
  function automatic weight_t comp_weight(input code_t f);
    return weight_t'(UNITY) - weight_t'(f);
  endfunction

  // Signed sample times unsigned weight; the product always fits FD_OUT_WD.
  function automatic fd_out_t wmul(input sample_t x, input weight_t w);
    fd_out_t xe;
    fd_out_t we;
    xe = fd_out_t'(x);
    we = fd_out_t'(w);
    return xe * we;
  endfunction

endpackage

// File: rtl/fine_delay_interp_lut.sv
// Fine-delay code LUT: one write port, one synchronous read-first read port.
module fd_code_lut
  import fine_delay_interp_pkg::*;
(
  input  logic               clk,
  input  logic               we,
  input  logic [ADDR_WD-1:0] waddr,
  input  code_t              wdata,
  input  logic [ADDR_WD-1:0] raddr,
  output code_t              rdata
);

  code_t mem [2**ADDR_WD];

  // Write and registered read share the edge; a colliding read sees old data.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/fine_delay_interp.sv
// Fine-delay stage: linear interpolation between current and previous sample
// with a per-focal-zone fractional code. Define FD_ZONE_SAT_EN to make the
// zone index saturate at the last zone instead of wrapping to zone 0.
module fine_delay_interp
  import fine_delay_interp_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tx_en,
  input  logic                 start,
  input  logic [ADDR_WD-1:0]   lut_addr,
  input  logic                 lut_we,
  input  logic [FRAC_WD-1:0]   lut_wdata,
  input  logic [INPUT_WD-1:0]  fine_din,
  input  logic                 fine_din_valid,
  output logic [FD_OUT_WD-1:0] fine_dout,
  output logic                 fine_dout_valid
);

  logic               start_d;
  logic               rise;
  logic               acc;
  logic [CNT_WD-1:0]  zone_cnt, cnt_base, cnt_nxt;
  logic [ADDR_WD-1:0] zone_idx, idx_base, idx_nxt, idx_adv;
  sample_t            history, hist_base, hist_nxt;

  code_t              f_s1;
  logic               v_s1;
  sample_t            x0_s1, x1_s1;
  logic               v_s2;
  fd_out_t            p0_s2, p1_s2;

  // Line-start edge and sample accept qualifier.
  always_comb begin
    rise = start & ~start_d;
    acc  = start & ~tx_en & fine_din_valid;
  end

  // A start edge zeroes the counters and history before this cycle's sample
  // is considered, so an accept on that edge is zone 0 with previous 0.
  always_comb begin
    cnt_base  = rise ? '0 : zone_cnt;
    idx_base  = rise ? '0 : zone_idx;
    hist_base = rise ? '0 : history;
  end

  // Zone index advance policy.
  always_comb begin
`ifdef FD_ZONE_SAT_EN
    idx_adv = (idx_base == '1) ? idx_base : idx_base + 1'b1;
`else
    idx_adv = idx_base + 1'b1;
`endif
  end

  // Next-state for zone counters and history.
  always_comb begin
    cnt_nxt  = cnt_base;
    idx_nxt  = idx_base;
    hist_nxt = hist_base;
    if (acc) begin
      hist_nxt = sample_t'(fine_din);
      if (cnt_base == CNT_WD'(ZONE_LEN - 1)) begin
        cnt_nxt = '0;
        idx_nxt = idx_adv;
      end else begin
        cnt_nxt = cnt_base + 1'b1;
      end
    end
    if (!start) begin
      cnt_nxt = '0;
      idx_nxt = '0;
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_d  <= 1'b0;
      zone_cnt <= '0;
      zone_idx <= '0;
      history  <= '0;
    end else begin
      start_d  <= start;
      zone_cnt <= cnt_nxt;
      zone_idx <= idx_nxt;
      history  <= hist_nxt;
    end
  end

  // The code is looked up with the zone in effect at accept time.
  fd_code_lut u_lut (
    .clk   (clk),
    .we    (lut_we),
    .waddr (lut_addr),
    .wdata (lut_wdata),
    .raddr (idx_base),
    .rdata (f_s1)
  );

  // S1: capture current and previous sample alongside the LUT read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_s1  <= 1'b0;
      x0_s1 <= '0;
      x1_s1 <= '0;
    end else begin
      v_s1 <= acc;
      if (acc) begin
        x0_s1 <= sample_t'(fine_din);
        x1_s1 <= hist_base;
      end
    end
  end

  // S2: weighted products.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_s2  <= 1'b0;
      p0_s2 <= '0;
      p1_s2 <= '0;
    end else begin
      v_s2 <= v_s1 & ~tx_en;
      if (v_s1) begin
        p0_s2 <= wmul(x0_s1, comp_weight(f_s1));
        p1_s2 <= wmul(x1_s1, weight_t'(f_s1));
      end
    end
  end

  // S3: full-precision sum; output holds when no sample completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fine_dout_valid <= 1'b0;
      fine_dout       <= '0;
    end else begin
      fine_dout_valid <= v_s2 & ~tx_en;
      if (v_s2 && !tx_en) begin
        fine_dout <= p0_s2 + p1_s2;
      end
    end
  end

endmodule
